// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares CDB_PORTS common-data-bus broadcast slots among NUM_REQ
// writeback requesters. The grant is round-robin and combinational, and the
// broadcast is registered, so a request granted in cycle N appears on cdb_*
// in cycle N+1. A branch flush suppresses every grant and squashes the
// broadcast registered at the next edge.
// Optional build macro CDB_ARB_PERF_EN adds the grant and conflict counters.
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CDB_PORTS     = 2,
  parameter int PHYS_WIDTH    = 6,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     br_flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [PHYS_WIDTH-1:0]    req_paddr   [NUM_REQ],
  input  logic [ROB_IDX_WIDTH-1:0] req_rob_idx [NUM_REQ],
  input  logic [DATA_WIDTH-1:0]    req_data    [NUM_REQ],
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [CDB_PORTS-1:0]     cdb_valid,
  output logic [PHYS_WIDTH-1:0]    cdb_paddr   [CDB_PORTS],
  output logic [ROB_IDX_WIDTH-1:0] cdb_rob_idx [CDB_PORTS],
  output logic [DATA_WIDTH-1:0]    cdb_data    [CDB_PORTS]
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]              perf_conflict_cnt,
  output logic [31:0]              perf_grant_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [CDB_PORTS-1:0] port_used;
  logic [PTR_W-1:0]     port_src [CDB_PORTS];

  // Scan from rr_ptr with wrap; the k-th valid requester found takes port k.
  always_comb begin
    int n_granted;
    int scan_i;
    logic [PTR_W-1:0] scan_idx;
    // NOTE: every variable written here gets a default first, so no path can
    // leave a value unassigned and a latch can never be inferred.
    grant      = '0;
    port_used  = '0;
    rr_ptr_nxt = rr_ptr;
    n_granted  = 0;
    scan_i     = 0;
    scan_idx   = '0;
    for (int p = 0; p < CDB_PORTS; p++) port_src[p] = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_i   = (int'(rr_ptr) + j) % NUM_REQ;
      scan_idx = PTR_W'(scan_i);
      if (req_valid[scan_idx] && (n_granted < CDB_PORTS)) begin
        grant[scan_idx] = 1'b1;
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (n_granted == p) begin
            port_used[p] = 1'b1;
            port_src[p]  = scan_idx;
          end
        end
        rr_ptr_nxt = PTR_W'((scan_i + 1) % NUM_REQ);
        n_granted++;
      end
    end
    // Reset and flush suppress every grant; there are no partial grants.
    if (!rst_n || br_flush) begin
      grant     = '0;
      port_used = '0;
    end
  end

  assign req_ready = grant;

  // Register the granted payloads onto the bus and advance the priority pointer.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      for (int p = 0; p < CDB_PORTS; p++) begin
        cdb_paddr[p]   <= '0;
        cdb_rob_idx[p] <= '0;
        cdb_data[p]    <= '0;
      end
    end else if (br_flush) begin
      cdb_valid <= '0;
    end else begin
      cdb_valid <= port_used;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (port_used[p]) begin
          cdb_paddr[p]   <= req_paddr[port_src[p]];
          cdb_rob_idx[p] <= req_rob_idx[port_src[p]];
          cdb_data[p]    <= req_data[port_src[p]];
        end
      end
      if (|grant) rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef CDB_ARB_PERF_EN
  // Count grants and cycles with at least one valid requester left waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
      perf_grant_cnt    <= '0;
    end else if (!br_flush) begin
      if (|(req_valid & ~grant)) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      perf_grant_cnt <= perf_grant_cnt + 32'($countones(grant));
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven directed vectors, hand-written reset, single
// request and perf sequences, then randomized traffic against a behavioural
// model of the round-robin broadcast arbiter.
module tb_cdb_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CDB_PORTS = 2;
  localparam int PW        = 6;
  localparam int RW        = 5;
  localparam int DW        = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 br_flush;
  logic [NUM_REQ-1:0]   req_valid;
  logic [PW-1:0]        req_paddr   [NUM_REQ];
  logic [RW-1:0]        req_rob_idx [NUM_REQ];
  logic [DW-1:0]        req_data    [NUM_REQ];
  logic [NUM_REQ-1:0]   req_ready;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [PW-1:0]        cdb_paddr   [CDB_PORTS];
  logic [RW-1:0]        cdb_rob_idx [CDB_PORTS];
  logic [DW-1:0]        cdb_data    [CDB_PORTS];
`ifdef CDB_ARB_PERF_EN
  logic [31:0]          perf_conflict_cnt;
  logic [31:0]          perf_grant_cnt;
`endif

  cdb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_flush   (br_flush),
    .req_valid  (req_valid),
    .req_paddr  (req_paddr),
    .req_rob_idx(req_rob_idx),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_paddr  (cdb_paddr),
    .cdb_rob_idx(cdb_rob_idx),
    .cdb_data   (cdb_data)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_conflict_cnt(perf_conflict_cnt),
    .perf_grant_cnt   (perf_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] pl(input int i, input int s);
    return {PW'(i * 13 + s), RW'(i + 3 * s), 32'hA5A50000 + DW'(s * 256 + i)};
  endfunction

  function automatic logic [42:0] bus_pl(input int k);
    return {cdb_paddr[k], cdb_rob_idx[k], cdb_data[k]};
  endfunction

  task automatic drive_pl(input int i, input logic [42:0] v);
    {req_paddr[i], req_rob_idx[i], req_data[i]} = v;
  endtask

  // ---------------- behavioural model ----------------
  int                   m_ptr;
  logic [NUM_REQ-1:0]   g_mask;
  int                   g_list[$];
  logic [CDB_PORTS-1:0] exp_v;
  logic [42:0]          exp_pl [CDB_PORTS];
  logic [CDB_PORTS-1:0] pl_chk;
  logic [31:0]          m_conf, m_gcnt;

  // Valid requesters listed in rotated priority order; the first CDB_PORTS win.
  task automatic model_grant(input logic [NUM_REQ-1:0] v, input logic blocked);
    int order[$];
    g_mask = '0;
    g_list = {};
    for (int j = 0; j < NUM_REQ; j++) order.push_back((m_ptr + j) % NUM_REQ);
    if (!blocked)
      foreach (order[j])
        if (v[order[j]] && g_list.size() < CDB_PORTS) g_list.push_back(order[j]);
    foreach (g_list[k]) g_mask[g_list[k]] = 1'b1;
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_ptr  = 0;
      exp_v  = '0;
      pl_chk = '1;
      for (int k = 0; k < CDB_PORTS; k++) exp_pl[k] = '0;
      m_conf = '0;
      m_gcnt = '0;
    end else begin
      pl_chk = '0;
      exp_v  = '0;
      if (!br_flush) begin
        foreach (g_list[k]) begin
          exp_v[k]  = 1'b1;
          exp_pl[k] = {req_paddr[g_list[k]], req_rob_idx[g_list[k]], req_data[g_list[k]]};
        end
        if (g_list.size() > 0) m_ptr = (g_list[g_list.size() - 1] + 1) % NUM_REQ;
        if ((req_valid & ~g_mask) != '0) m_conf = m_conf + 1;
        m_gcnt = m_gcnt + 32'(g_list.size());
      end
    end
  endtask

  // Inputs are set by the caller at a falling edge; this checks one full cycle.
  task automatic run_cycle(input string tag);
    model_grant(req_valid, br_flush || !rst_n);
    #1 check({tag, "_ready"}, 64'(req_ready), 64'(g_mask));
    @(posedge clk);
    model_commit();
    #1 check({tag, "_cdb_valid"}, 64'(cdb_valid), 64'(exp_v));
    for (int k = 0; k < CDB_PORTS; k++)
      if (exp_v[k] || pl_chk[k]) check($sformatf("%s_payload%0d", tag, k), 64'(bus_pl(k)), 64'(exp_pl[k]));
`ifdef CDB_ARB_PERF_EN
    check({tag, "_perf_conflict"}, 64'(perf_conflict_cnt), 64'(m_conf));
    check({tag, "_perf_grant"}, 64'(perf_grant_cnt), 64'(m_gcnt));
`endif
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NUM_REQ-1:0]   valid;
    logic                 flush;
    logic [NUM_REQ-1:0]   exp_ready;
    logic [CDB_PORTS-1:0] exp_v;
    int                   src0;
    int                   src1;
  } vec_t;

  vec_t tbl [11];
  logic [NUM_REQ-1:0] pend;

  initial begin
    // Rows run back to back from reset (pointer starts at 0).
    tbl[0]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1}; // fairness {0,1}
    tbl[1]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3}; // {2,3}
    tbl[2]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3}; // ptr back to 0
    tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 2'b01, 2, 0}; // single, ptr -> 3
    tbl[5]  = '{4'b1011, 1'b0, 4'b1001, 2'b11, 3, 0}; // wrap 3,0, ptr -> 1
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 2'b00, 0, 0}; // flush, ptr holds 1
    tbl[7]  = '{4'b1111, 1'b0, 4'b0110, 2'b11, 1, 2}; // ptr -> 3
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0}; // idle, ptr holds
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 2'b01, 0, 0}; // ptr -> 1
    tbl[10] = '{4'b1110, 1'b0, 4'b0110, 2'b11, 1, 2}; // ptr -> 3

    rst_n     = 1'b0;
    br_flush  = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) drive_pl(i, pl(i, 99));
    @(negedge clk);

    // Reset for two cycles with all requesters valid; flush during reset too.
    for (int c = 0; c < 2; c++) begin
      br_flush = (c == 1);
      #1 check("reset_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
      for (int k = 0; k < CDB_PORTS; k++) check("reset_payload", 64'(bus_pl(k)), 64'd0);
      @(negedge clk);
    end
    br_flush = 1'b0;

    // Directed table.
    rst_n = 1'b1;
    for (int s = 0; s < 11; s++) begin
      br_flush  = tbl[s].flush;
      req_valid = tbl[s].valid;
      for (int i = 0; i < NUM_REQ; i++) drive_pl(i, pl(i, s));
      #1 check($sformatf("tbl%0d_ready", s), 64'(req_ready), 64'(tbl[s].exp_ready));
      @(posedge clk);
      #1 check($sformatf("tbl%0d_cdb_valid", s), 64'(cdb_valid), 64'(tbl[s].exp_v));
      if (tbl[s].exp_v[0]) check($sformatf("tbl%0d_port0", s), 64'(bus_pl(0)), 64'(pl(tbl[s].src0, s)));
      if (tbl[s].exp_v[1]) check($sformatf("tbl%0d_port1", s), 64'(bus_pl(1)), 64'(pl(tbl[s].src1, s)));
      @(negedge clk);
    end
    br_flush = 1'b0;

    // Single request with a known payload (pointer is 3 here).
    req_valid = 4'b0100;
    drive_pl(2, {6'h15, 5'd7, 32'hDEADBEEF});
    #1 check("single_ready", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1 check("single_cdb_valid", 64'(cdb_valid), 64'b01);
    check("single_payload", 64'(bus_pl(0)), 64'({6'h15, 5'd7, 32'hDEADBEEF}));
    @(negedge clk);

    // Three requesters held valid for five cycles after a reset.
    rst_n     = 1'b0;
    req_valid = '0;
    run_cycle("perf_rst");
    rst_n     = 1'b1;
    req_valid = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NUM_REQ; i++) drive_pl(i, pl(i, 40 + c));
      run_cycle("perf");
    end
`ifdef CDB_ARB_PERF_EN
    check("perf_grant_total", 64'(perf_grant_cnt), 64'd10);
    check("perf_conflict_total", 64'(perf_conflict_cnt), 64'd5);
`endif

    // Randomized traffic; requesters hold valid and payload until granted.
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(63) != 0);
      br_flush = ($urandom_range(7) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1'b1;
          drive_pl(i, {PW'($urandom), RW'($urandom), DW'($urandom)});
        end
      end
      req_valid = pend;
      run_cycle("rand");
      pend = pend & ~g_mask;
      if (rst_n && br_flush)
        for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(1) == 1) pend[i] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the CDB_PORTS common-data-bus broadcast slots among NUM_REQ functional-unit writeback requesters.
- Uses round-robin priority and a one-cycle registered output stage.
- The registered outputs drive cdb_valid/cdb_paddr, which are consumed by the physical-register valid array, the reservation stations and the ROB.
- Squashes in-flight broadcasts on branch flush.

Parameters:
- NUM_REQ, 4, number of writeback requesters (FUs); must be >= CDB_PORTS.
- CDB_PORTS, 2, broadcast slots per cycle.
- PHYS_WIDTH, 6, physical register tag width.
- ROB_IDX_WIDTH, 5, ROB index width.
- DATA_WIDTH, 32, result data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- br_flush  in  1  branch mispredict flush.
- req_valid[NUM_REQ]  in  1  requester i has a result.
- req_paddr[NUM_REQ]  in  PHYS_WIDTH  destination physical register.
- req_rob_idx[NUM_REQ]  in  ROB_IDX_WIDTH  ROB entry.
- req_data[NUM_REQ]  in  DATA_WIDTH  result value.
- req_ready[NUM_REQ]  out  1  grant; transfer occurs when req_valid & req_ready.
- cdb_valid[CDB_PORTS]  out  1  broadcast slot p is valid.
- cdb_paddr[CDB_PORTS]  out  PHYS_WIDTH  broadcast tag.
- cdb_rob_idx[CDB_PORTS]  out  ROB_IDX_WIDTH  broadcast ROB index.
- cdb_data[CDB_PORTS]  out  DATA_WIDTH  broadcast data.

Behaviour:
- State:
  - rr_ptr, $clog2(NUM_REQ) bits.
  - Output registers for all cdb_* signals.
- Reset (rst_n low at a clock edge):
  - rr_ptr <= 0; cdb_valid <= 0; cdb_paddr/cdb_rob_idx/cdb_data <= 0.
  - req_ready is combinational and forced to 0 while rst_n is low.
- Grant selection (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - The first CDB_PORTS requesters with req_valid=1 are granted.
  - The k-th granted requester in scan order maps to port k (k = 0..CDB_PORTS-1).
  - req_ready[i]=1 iff i is granted. Each requester is granted at most once per cycle.
- Handshake rules:
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
  - A requester holds valid and payload stable until it sees ready.
- Latency:
  - A request granted in cycle N appears on cdb_* in cycle N+1.
  - Unused ports have cdb_valid=0 in N+1; their payload holds its previous value and is don't-care.
- Pointer update:
  - If any grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant occurs, rr_ptr holds.
  - Guarantee: any continuously-valid requester is granted within ceil(NUM_REQ/CDB_PORTS) cycles.
- br_flush=1:
  - All req_ready forced to 0 that cycle.
  - cdb_valid <= 0 at the edge.
  - rr_ptr holds.
  - Requesters are responsible for dropping wrong-path results.
- Precedence: flush during reset → reset wins. Flush suppresses all grants, with no partial grants.
- Fewer valid requests than ports: all valid requests are granted the same cycle.
- No backpressure from CDB consumers: every grant is committed to a broadcast.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- With the macro defined, two extra outputs are present:
  - perf_conflict_cnt (32 bits): +1 each non-flush, non-reset cycle in which at least one req_valid is not granted.
  - perf_grant_cnt (32 bits): + number of grants in that cycle.
  - Both counters are zeroed on reset, wrap on overflow, and do not count during br_flush.
- Without the macro: these ports and the counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all req_valid=1 → req_ready all 0; after release, cdb_valid=0 until the first grant edge; rr_ptr=0.
- Single request: req_valid[2]=1, paddr=6'h15, rob=5'd7, data=32'hDEADBEEF in cycle N → req_ready[2]=1 in N; in N+1 cdb_valid[0]=1 with paddr 6'h15, rob 7, data DEADBEEF; cdb_valid[1]=0.
- Fairness: all 4 requesters held valid for 4 cycles from reset → grants {0,1}, {2,3}, {0,1}, {2,3}, each mapped to ports 0 and 1 in scan order.
- Wrap-around: rr_ptr=3, req_valid={0,1,3} → grants 3→port0 and 0→port1; next rr_ptr=1.
- Flush: grant in cycle N, br_flush=1 in cycle N+1 with requesters valid → cdb_valid from the cycle-N grant visible in N+1; in N+1 req_ready all 0; in N+2 cdb_valid all 0; rr_ptr unchanged.
- Perf counters (CDB_ARB_PERF_EN): 3 requesters valid for 5 cycles → perf_grant_cnt=10, perf_conflict_cnt=5.
